// File: rtl/trap_ctrl_if.sv
// Pipeline/CSR-side signal bundle for the machine-mode trap controller.
// master = pipeline and CSR unit, slave = trap_ctrl.
interface trap_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            excReq;
  logic [4:0]      excCause;
  logic [XLEN-1:0] excPc;
  logic            irqPending;
  logic            irqEnable;
  logic [XLEN-1:0] nextPc;
  logic            mretReq;
  logic            swCsrWe;
  logic [11:0]     swCsrA;
  logic [XLEN-1:0] swCsrDi;
  logic            csrWe;
  logic [11:0]     csrA;
  logic [XLEN-1:0] csrDi;
  logic [XLEN-1:0] mepcDo;
  logic [XLEN-1:0] mtvecDo;
  logic            mepcWe;
  logic [XLEN-1:0] mepcDi;
  logic            mcauseWe;
  logic [XLEN-1:0] mcauseDi;
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirectPc;
  logic            inTrap;

  modport master (
    output excReq, excCause, excPc, irqPending, irqEnable, nextPc, mretReq,
           swCsrWe, swCsrA, swCsrDi, mepcDo, mtvecDo,
    input  csrWe, csrA, csrDi, mepcWe, mepcDi, mcauseWe, mcauseDi,
           stall, redirect, redirectPc, inTrap
  );

  modport slave (
    input  excReq, excCause, excPc, irqPending, irqEnable, nextPc, mretReq,
           swCsrWe, swCsrA, swCsrDi, mepcDo, mtvecDo,
    output csrWe, csrA, csrDi, mepcWe, mepcDi, mcauseWe, mcauseDi,
           stall, redirect, redirectPc, inTrap
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry/return sequencer: saves mepc/mcause, redirects fetch
// to mtvec (direct or vectored) or back to mepc, and arbitrates the CSR write port.
module trap_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IRQ_CODE = 11
) (
  input logic       clk,
  input logic       reset,
  trap_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SAVE, S_JUMP, S_RET} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_savedPc;
  logic [XLEN-1:0] r_savedCause;
  logic            r_isIrq;
  logic            r_inTrap;
  logic            r_mepcWe;
  logic            r_mcauseWe;
  logic            r_stall;
  logic            r_redirect;

  logic            w_irqTake;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_vecOff;
  logic [XLEN-1:0] w_redirectPc;

  assign w_irqTake = bus.irqPending & bus.irqEnable & ~r_inTrap;
  assign w_base    = bus.mtvecDo & ~XLEN'(3);
  assign w_vecOff  = XLEN'(IRQ_CODE) << 2;

  // Strobes are registered on the transition into the state that owns them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_savedPc    <= '0;
      r_savedCause <= '0;
      r_isIrq      <= 1'b0;
      r_inTrap     <= 1'b0;
      r_mepcWe     <= 1'b0;
      r_mcauseWe   <= 1'b0;
      r_stall      <= 1'b0;
      r_redirect   <= 1'b0;
    end else begin
      r_mepcWe   <= 1'b0;
      r_mcauseWe <= 1'b0;
      r_stall    <= 1'b0;
      r_redirect <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.excReq) begin
            r_savedPc    <= bus.excPc;
            r_savedCause <= {{(XLEN-5){1'b0}}, bus.excCause};
            r_isIrq      <= 1'b0;
            r_state      <= S_SAVE;
            r_mepcWe     <= 1'b1;
            r_mcauseWe   <= 1'b1;
            r_stall      <= 1'b1;
          end else if (w_irqTake) begin
            r_savedPc    <= bus.nextPc;
            r_savedCause <= {1'b1, (XLEN-1)'(IRQ_CODE)};
            r_isIrq      <= 1'b1;
            r_state      <= S_SAVE;
            r_mepcWe     <= 1'b1;
            r_mcauseWe   <= 1'b1;
            r_stall      <= 1'b1;
          end else if (bus.mretReq) begin
            r_state    <= S_RET;
            r_stall    <= 1'b1;
            r_redirect <= 1'b1;
          end
        end
        S_SAVE: begin
          r_state    <= S_JUMP;
          r_stall    <= 1'b1;
          r_redirect <= 1'b1;
        end
        S_JUMP: begin
          r_inTrap <= 1'b1;
          r_state  <= S_IDLE;
        end
        S_RET: begin
          r_inTrap <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Target follows the live mtvec/mepc values during JUMP/RET.
  always_comb begin
    w_redirectPc = '0;
    case (r_state)
      S_JUMP: w_redirectPc = (bus.mtvecDo[1:0] == 2'b01 && r_isIrq) ? w_base + w_vecOff : w_base;
      S_RET:  w_redirectPc = bus.mepcDo & ~XLEN'(3);
      default: w_redirectPc = '0;
    endcase
  end

  assign bus.csrWe      = bus.swCsrWe & (r_state == S_IDLE) & ~bus.excReq;
  assign bus.csrA       = bus.swCsrA;
  assign bus.csrDi      = bus.swCsrDi;
  assign bus.mepcWe     = r_mepcWe;
  assign bus.mepcDi     = r_savedPc;
  assign bus.mcauseWe   = r_mcauseWe;
  assign bus.mcauseDi   = r_savedCause;
  assign bus.stall      = r_stall;
  assign bus.redirect   = r_redirect;
  assign bus.redirectPc = w_redirectPc;
  assign bus.inTrap     = r_inTrap;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a step-queue model of trap/mret sequences is
// checked every cycle, plus literal expectations at key points.
module tb_trap_ctrl;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned IRQ_CODE = 11;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  trap_ctrl_if #(.XLEN(XLEN)) bus ();

  trap_ctrl #(.XLEN(XLEN), .IRQ_CODE(IRQ_CODE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending cycles of a trap/mret sequence, one entry per stalled cycle.
  typedef enum {K_SAVE, K_JUMP, K_RET} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] pc;
    logic [31:0] cause;
    bit          irq;
  } step_t;

  step_t       q[$];
  step_t       cur;
  bit          m_inTrap;
  bit          busy;
  logic        eStall, eRedir, eMw, eCsrWe;
  logic [31:0] eRpc;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_stall",    bus.stall,      1'b0);
      chk("rst_redirect", bus.redirect,   1'b0);
      chk("rst_mepcWe",   bus.mepcWe,     1'b0);
      chk("rst_mcauseWe", bus.mcauseWe,   1'b0);
      chk("rst_rpc",      bus.redirectPc, 32'h0);
      chk("rst_inTrap",   bus.inTrap,     1'b0);
      q.delete();
      m_inTrap = 1'b0;
    end else begin
      busy   = (q.size() != 0);
      eStall = 1'b0; eRedir = 1'b0; eMw = 1'b0; eRpc = 32'h0;
      if (busy) begin
        cur    = q[0];
        eStall = 1'b1;
        case (cur.kind)
          K_SAVE: begin
            eMw = 1'b1;
            chk("mepcDi",   bus.mepcDi,   cur.pc);
            chk("mcauseDi", bus.mcauseDi, cur.cause);
          end
          K_JUMP: begin
            eRedir = 1'b1;
            eRpc   = {bus.mtvecDo[31:2], 2'b00};
            if (cur.irq && bus.mtvecDo[1:0] == 2'b01) eRpc = eRpc + 4 * IRQ_CODE;
          end
          default: begin
            eRedir = 1'b1;
            eRpc   = {bus.mepcDo[31:2], 2'b00};
          end
        endcase
      end
      eCsrWe = !busy && bus.swCsrWe && !bus.excReq;
      chk("stall",      bus.stall,      eStall);
      chk("redirect",   bus.redirect,   eRedir);
      chk("redirectPc", bus.redirectPc, eRpc);
      chk("mepcWe",     bus.mepcWe,     eMw);
      chk("mcauseWe",   bus.mcauseWe,   eMw);
      chk("inTrap",     bus.inTrap,     m_inTrap);
      chk("csrWe",      bus.csrWe,      eCsrWe);
      chk("csrA",       bus.csrA,       bus.swCsrA);
      chk("csrDi",      bus.csrDi,      bus.swCsrDi);
      if (busy) begin
        if (cur.kind == K_JUMP) m_inTrap = 1'b1;
        if (cur.kind == K_RET)  m_inTrap = 1'b0;
        void'(q.pop_front());
      end else if (bus.excReq) begin
        q.push_back('{K_SAVE, bus.excPc, {27'h0, bus.excCause}, 1'b0});
        q.push_back('{K_JUMP, 32'h0, 32'h0, 1'b0});
      end else if (bus.irqPending && bus.irqEnable && !m_inTrap) begin
        q.push_back('{K_SAVE, bus.nextPc, 32'h8000_0000 | IRQ_CODE, 1'b1});
        q.push_back('{K_JUMP, 32'h0, 32'h0, 1'b1});
      end else if (bus.mretReq) begin
        q.push_back('{K_RET, 32'h0, 32'h0, 1'b0});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mret();
    bus.mepcDo = 32'h86; bus.mretReq = 1'b1;
    tick();
    bus.mretReq = 1'b0;
    #1;
    chk("mret_redirect", bus.redirect,   1'b1);
    chk("mret_rpc",      bus.redirectPc, 32'h84);
    chk("mret_stall",    bus.stall,      1'b1);
    tick();
    chk("mret_inTrap",   bus.inTrap,     1'b0);
    chk("mret_nostall",  bus.stall,      1'b0);
  endtask

  initial begin
    bus.excReq = 0; bus.excCause = '0; bus.excPc = '0; bus.irqPending = 0;
    bus.irqEnable = 0; bus.nextPc = '0; bus.mretReq = 0; bus.swCsrWe = 0;
    bus.swCsrA = '0; bus.swCsrDi = '0; bus.mepcDo = '0; bus.mtvecDo = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Reset aborting a SAVE cycle
    bus.excReq = 1; bus.excCause = 5'd3; bus.excPc = 32'h10; bus.mtvecDo = 32'h100;
    tick();
    bus.excReq = 0;
    #1;
    chk("pre_rst_mepcWe", bus.mepcWe, 1'b1);
    reset = 1'b0;
    #1;
    chk("arst_mepcWe",   bus.mepcWe,   1'b0);
    chk("arst_mcauseWe", bus.mcauseWe, 1'b0);
    chk("arst_stall",    bus.stall,    1'b0);
    chk("arst_redirect", bus.redirect, 1'b0);
    chk("arst_inTrap",   bus.inTrap,   1'b0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("post_rst_mepcWe", bus.mepcWe, 1'b0);
    chk("post_rst_stall",  bus.stall,  1'b0);

    // Vectored interrupt
    bus.irqPending = 1; bus.irqEnable = 1; bus.nextPc = 32'h44; bus.mtvecDo = 32'h201;
    tick();
    chk("irq_mepcWe",   bus.mepcWe,   1'b1);
    chk("irq_mepcDi",   bus.mepcDi,   32'h44);
    chk("irq_mcauseDi", bus.mcauseDi, 32'h8000_000B);
    tick();
    chk("irq_redirect", bus.redirect,   1'b1);
    chk("irq_rpc",      bus.redirectPc, 32'h22C);
    tick();
    chk("irq_inTrap",   bus.inTrap, 1'b1);
    repeat (2) begin
      tick();
      chk("irq_masked_stall",  bus.stall,  1'b0);
      chk("irq_masked_mepcWe", bus.mepcWe, 1'b0);
    end
    bus.irqPending = 0;
    do_mret();

    // Exception
    bus.excReq = 1; bus.excCause = 5'd2; bus.excPc = 32'h80; bus.mtvecDo = 32'h100;
    tick();
    bus.excReq = 0;
    #1;
    chk("exc_mepcWe",   bus.mepcWe,   1'b1);
    chk("exc_mepcDi",   bus.mepcDi,   32'h80);
    chk("exc_mcauseDi", bus.mcauseDi, 32'h2);
    tick();
    chk("exc_redirect", bus.redirect,   1'b1);
    chk("exc_rpc",      bus.redirectPc, 32'h100);
    tick();
    chk("exc_inTrap",   bus.inTrap, 1'b1);
    do_mret();

    // Priority: exception beats interrupt and mret; exceptions are not vectored
    bus.excReq = 1; bus.excCause = 5'd5; bus.excPc = 32'h90;
    bus.irqPending = 1; bus.irqEnable = 1; bus.mretReq = 1; bus.mtvecDo = 32'h201;
    tick();
    bus.excReq = 0; bus.irqPending = 0; bus.mretReq = 0;
    #1;
    chk("pri_mcauseDi", bus.mcauseDi, 32'h5);
    chk("pri_mepcDi",   bus.mepcDi,   32'h90);
    tick();
    chk("pri_rpc",      bus.redirectPc, 32'h200);
    tick();

    // CSR write arbitration, with a nested exception while inTrap=1
    bus.swCsrWe = 1; bus.swCsrA = 12'h305; bus.swCsrDi = 32'hFC;
    #1;
    chk("arb_idle_we", bus.csrWe, 1'b1);
    chk("arb_idle_a",  bus.csrA,  12'h305);
    chk("arb_idle_di", bus.csrDi, 32'hFC);
    bus.excReq = 1; bus.excCause = 5'd7; bus.excPc = 32'hA4; bus.mtvecDo = 32'h100;
    #1;
    chk("arb_exc_we", bus.csrWe, 1'b0);
    tick();
    bus.excReq = 0;
    #1;
    chk("arb_save_we",   bus.csrWe,  1'b0);
    chk("nest_mepcDi",   bus.mepcDi, 32'hA4);
    tick();
    chk("arb_jump_we",   bus.csrWe,  1'b0);
    tick();
    chk("arb_after_we",  bus.csrWe,  1'b1);
    bus.swCsrWe = 0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
